// File: rtl/alu_pkg.sv
// Shared definitions for the sign-magnitude ALU command path.
package alu_pkg;

    localparam int MAG_W = 4;   // operand magnitude width
    localparam int RES_W = 5;   // result magnitude width (carry out of 4-bit add)

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_NEGB = 3'd2;
    localparam logic [2:0] OP_EQ   = 3'd3;
    localparam logic [2:0] OP_GT   = 3'd4;
    localparam logic [2:0] OP_LT   = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [2:0]       op;
        logic             sa;
        logic [MAG_W-1:0] a;
        logic             sb;
        logic [MAG_W-1:0] b;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    // The ALU mishandles -0, so a zero magnitude always carries a positive sign.
    function automatic logic norm_sign(input logic s, input logic [MAG_W-1:0] m);
        return s && (m != '0);
    endfunction

endpackage

// File: rtl/sync_cmd_fifo.sv
// Single-clock FIFO with registered storage and extra-bit wrap pointers.
module sync_cmd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO is dropped even if a pop happens the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives them to the ALU one at a time, and returns results.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [MAG_W-1:0] cmd_a,
    input  logic [MAG_W-1:0] cmd_b,
    input  logic             cmd_sa,
    input  logic             cmd_sb,
    output logic [MAG_W-1:0] alu_a,
    output logic [MAG_W-1:0] alu_b,
    output logic             alu_sa,
    output logic             alu_sb,
    output logic [2:0]       alu_sel,
    input  logic [RES_W-1:0] alu_f,
    input  logic             alu_sf,
    input  logic             alu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_op,
    output logic [RES_W-1:0] rsp_f,
    output logic             rsp_sf,
    output logic             rsp_status,
    output logic             busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    alu_cmd_t         w_cmd_in;
    alu_cmd_t         w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_capture;
    logic             w_rsp_done;

    logic [MAG_W-1:0] r_alu_a;
    logic [MAG_W-1:0] r_alu_b;
    logic             r_alu_sa;
    logic             r_alu_sb;
    logic [2:0]       r_alu_sel;
    logic             r_rsp_valid;
    logic [2:0]       r_rsp_op;
    logic [RES_W-1:0] r_rsp_f;
    logic             r_rsp_sf;
    logic             r_rsp_status;

    // Push normaliser: -0 operands are stored as +0.
    always_comb begin
        w_cmd_in    = '0;
        w_cmd_in.op = cmd_op;
        w_cmd_in.a  = cmd_a;
        w_cmd_in.b  = cmd_b;
        w_cmd_in.sa = norm_sign(cmd_sa, cmd_a);
        w_cmd_in.sb = norm_sign(cmd_sb, cmd_b);
    end

    assign cmd_ready = !w_full && !rst;
    assign w_push    = cmd_valid && cmd_ready;

    sync_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_cmd_in),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // FSM next state: one command in flight at a time.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_empty)              w_next = SETTLE;
            SETTLE:  if (r_cnt == CNT_W'(1))    w_next = RESP;
            RESP:    if (rsp_ready)             w_next = IDLE;
            default:                            w_next = IDLE;
        endcase
    end

    // FSM outputs: datapath strobes.
    always_comb begin
        w_pop      = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            IDLE:    w_pop      = !w_empty;
            SETTLE:  w_capture  = (r_cnt == CNT_W'(1));
            RESP:    w_rsp_done = rsp_ready;
            default: ;
        endcase
    end

    // ALU drive registers; they hold the last command until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sa  <= 1'b0;
            r_alu_sb  <= 1'b0;
            r_alu_sel <= '0;
        end else if (w_pop) begin
            r_alu_a   <= w_head.a;
            r_alu_b   <= w_head.b;
            r_alu_sa  <= w_head.sa;
            r_alu_sb  <= w_head.sb;
            r_alu_sel <= w_head.op;
        end
    end

    // Settle counter: loaded at pop, counts down while the ALU inputs settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_cnt <= '0;
        else if (w_pop)              r_cnt <= CNT_W'(SETTLE_CYCLES);
        else if (r_state == SETTLE)  r_cnt <= r_cnt - 1'b1;
    end

    // Response registers: captured once per command, held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_op     <= '0;
            r_rsp_f      <= '0;
            r_rsp_sf     <= 1'b0;
            r_rsp_status <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_op     <= r_alu_sel;
            r_rsp_f      <= alu_f;
            r_rsp_sf     <= (alu_f == '0) ? 1'b0 : alu_sf;
            r_rsp_status <= alu_status;
        end else if (w_rsp_done) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sa     = r_alu_sa;
    assign alu_sb     = r_alu_sb;
    assign alu_sel    = r_alu_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_op     = r_rsp_op;
    assign rsp_f      = r_rsp_f;
    assign rsp_sf     = r_rsp_sf;
    assign rsp_status = r_rsp_status;
    assign busy       = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural sign-magnitude ALU.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_a = '0, cmd_b = '0;
    logic       cmd_sa = 1'b0, cmd_sb = 1'b0;
    logic [3:0] alu_a, alu_b;
    logic       alu_sa, alu_sb;
    logic [2:0] alu_sel;
    logic [4:0] alu_f;
    logic       alu_sf, alu_status;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [2:0] rsp_op;
    logic [4:0] rsp_f;
    logic       rsp_sf, rsp_status;
    logic       busy;

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sa(alu_sa), .alu_sb(alu_sb), .alu_sel(alu_sel),
        .alu_f(alu_f), .alu_sf(alu_sf), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_f(rsp_f), .rsp_sf(rsp_sf), .rsp_status(rsp_status), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU. NEGB passes the raw magnitude and flips the sign, so a
    // zero magnitude comes back as -0 and exercises the response normalisation.
    int va, vb, vr;
    always_comb begin
        va = alu_sa ? -int'(alu_a) : int'(alu_a);
        vb = alu_sb ? -int'(alu_b) : int'(alu_b);
        vr = 0;
        alu_f = '0;
        alu_sf = 1'b0;
        alu_status = 1'b0;
        case (alu_sel)
            OP_ADD:  vr = va + vb;
            OP_SUB:  vr = va - vb;
            default: vr = 0;
        endcase
        if (alu_sel == OP_ADD || alu_sel == OP_SUB) begin
            alu_f  = 5'((vr < 0) ? -vr : vr);
            alu_sf = (vr < 0);
        end
        case (alu_sel)
            OP_NEGB: begin alu_f = {1'b0, alu_b}; alu_sf = !alu_sb; end
            OP_EQ:   alu_status = (va == vb);
            OP_GT:   alu_status = (va > vb);
            OP_LT:   alu_status = (va < vb);
            OP_AND:  begin alu_f = {1'b0, alu_a & alu_b}; alu_sf = alu_sa & alu_sb; end
            OP_XOR:  begin alu_f = {1'b0, alu_a ^ alu_b}; alu_sf = alu_sa ^ alu_sb; end
            default: ;
        endcase
    end

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] f;
        logic       sf;
        logic       st;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e, held;
    bit   held_v = 1'b0;
    bit   tp_on = 1'b0;
    int   tp_last = -1;
    int   errors = 0, checks = 0, rsp_cnt = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks stability while stalled, and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && rsp_valid)
                chk("rsp_stable", {rsp_op, rsp_f, rsp_sf, rsp_status}, held);
            held_v = rsp_valid && !rsp_ready;
            held   = {rsp_op, rsp_f, rsp_sf, rsp_status};
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: op=%0d f=%0d, none expected", rsp_op, rsp_f);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("rsp_op", rsp_op, mon_e.op);
                    chk("rsp_f", rsp_f, mon_e.f);
                    chk("rsp_sf", rsp_sf, mon_e.sf);
                    chk("rsp_status", rsp_status, mon_e.st);
                end
                if (tp_on) begin
                    if (tp_last >= 0) chk("rsp_interval", cyc - tp_last, 3);
                    tp_last = cyc;
                end
            end
        end
    end

    // Drive one command, wait (bounded) for acceptance, and record its expected response.
    task automatic push(input logic [2:0] op, input logic sa, input logic [3:0] a,
                        input logic sb, input logic [3:0] b, input bit want,
                        input logic [4:0] f, input logic sf, input logic st);
        int n = 0;
        cmd_op = op; cmd_sa = sa; cmd_a = a; cmd_sb = sb; cmd_b = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles", n);
            cmd_valid = 1'b0;
            return;
        end
        if (want) sb_q.push_back(exp_t'{op, f, sf, st});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rsp_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_idle", {busy, rsp_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu", {alu_a, alu_b, alu_sa, alu_sb, alu_sel}, 0);
        chk("rst_rsp", {rsp_op, rsp_f, rsp_sf, rsp_status}, 0);
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);

        // 3 + (-5) = -2, with latency check: response valid after push edge + 2.
        rsp_ready = 1'b1;
        push(OP_ADD, 0, 4'd3, 1, 4'd5, 1, 5'd2, 1, 0);
        chk("lat_n0", rsp_valid, 0);
        @(posedge clk); #1;
        chk("lat_n1", rsp_valid, 0);
        @(posedge clk); #1;
        chk("lat_n2", rsp_valid, 1);
        wait_idle();

        // NEGB of -0: operand sign stored as +0, response sign normalised.
        push(OP_NEGB, 0, 4'd0, 1, 4'd0, 1, 5'd0, 0, 0);
        @(posedge clk); #1;
        chk("negz_alu_sb", alu_sb, 0);
        chk("negz_alu_sel", alu_sel, OP_NEGB);
        wait_idle();
        chk("alu_hold_sel", alu_sel, OP_NEGB);

        // -2 > 1 is false, -2 < 1 is true; responses in order.
        push(OP_GT, 1, 4'd2, 0, 4'd1, 1, 5'd0, 0, 0);
        push(OP_LT, 1, 4'd2, 0, 4'd1, 1, 5'd0, 0, 1);
        wait_idle();

        // Backpressure: one command in flight plus four queued fill the path,
        // so the sixth push stalls until the first response is taken.
        rsp_ready = 1'b0;
        push(OP_SUB, 0, 4'd7,  0, 4'd2,  1, 5'd5,  0, 0);
        push(OP_SUB, 0, 4'd2,  0, 4'd7,  1, 5'd5,  1, 0);
        push(OP_EQ,  1, 4'd4,  1, 4'd4,  1, 5'd0,  0, 1);
        push(OP_AND, 1, 4'd12, 1, 4'd10, 1, 5'd8,  1, 0);
        push(OP_XOR, 1, 4'd12, 0, 4'd10, 1, 5'd6,  1, 0);
        cmd_op = OP_ADD; cmd_sa = 0; cmd_a = 4'd15; cmd_sb = 0; cmd_b = 4'd15;
        cmd_valid = 1'b1;
        chk("full_ready0", cmd_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_ready_hold", cmd_ready, 0);
        chk("full_rsp_op", rsp_op, OP_SUB);
        chk("full_rsp_f", rsp_f, 5);
        rsp_ready = 1'b1;
        push(OP_ADD, 0, 4'd15, 0, 4'd15, 1, 5'd30, 0, 0);
        wait_idle();

        // Back-to-back pushes with rsp_ready high: one response every 3 cycles.
        tp_last = -1;
        tp_on = 1'b1;
        push(OP_ADD,  1, 4'd1,  0, 4'd1, 1, 5'd0,  0, 0);
        push(OP_SUB,  0, 4'd0,  1, 4'd9, 1, 5'd9,  0, 0);
        push(OP_SUB,  1, 4'd15, 0, 4'd15, 1, 5'd30, 1, 0);
        push(OP_NEGB, 0, 4'd0,  0, 4'd6, 1, 5'd6,  1, 0);
        push(OP_EQ,   0, 4'd3,  1, 4'd3, 1, 5'd0,  0, 0);
        push(OP_GT,   0, 4'd9,  0, 4'd8, 1, 5'd0,  0, 1);
        push(OP_AND,  0, 4'd5,  1, 4'd3, 1, 5'd1,  0, 0);
        push(OP_XOR,  1, 4'd9,  1, 4'd9, 1, 5'd0,  0, 0);
        wait_idle();
        tp_on = 1'b0;

        // Reset while the second command settles with three more queued.
        rsp_ready = 1'b0;
        push(OP_ADD, 0, 4'd1, 0, 4'd2, 1, 5'd3, 0, 0);
        push(OP_ADD, 0, 4'd4, 0, 4'd4, 0, 5'd0, 0, 0);
        push(OP_SUB, 0, 4'd5, 0, 4'd1, 0, 5'd0, 0, 0);
        push(OP_AND, 0, 4'd7, 0, 4'd3, 0, 5'd0, 0, 0);
        push(OP_XOR, 0, 4'd6, 0, 4'd2, 0, 5'd0, 0, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("no_rsp_after_rst", rsp_cnt, 19);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
